axi_sram_slave: RTL

- Single-clock AXI4 responder: the slave-side endpoint that consumes AR/AW/W channel traffic leaving a crossbar master interface and returns R/B responses.
- Backed by an internal word-addressed SRAM array with byte strobes. Supports INCR and FIXED bursts.
- Handles one transaction at a time through a 4-state FSM with read/write round-robin arbitration.
- Used as the default memory target behind a crossbar slave port and as the bench target for crossbar tests.

---
 rtl/axi_sram_slave.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI4 memory responder with one transaction in flight. Consumes AR/AW/W
//   traffic and answers on R/B from an internal word-addressed SRAM built as
//   STRB_W independent byte banks, so byte strobes map to per-bank write
//   enables. INCR and FIXED bursts are serviced; WRAP and the reserved burst
//   encoding are answered with SLVERR and never touch the memory.
//
// Ports
//   AXI_CLK_i / AXI_RST_i  clock, synchronous active-high reset
//   AW*  write address channel   (AWREADY_o driven combinationally in IDLE)
//   W*   write data channel      (WREADY_o high for the whole WDATA state)
//   B*   write response channel  (registered, held until BREADY_i)
//   AR*  read address channel    (ARREADY_o driven combinationally in IDLE)
//   R*   read data channel       (registered, first beat one cycle after AR)
//
// AWSIZE/ARSIZE are ignored: every beat is treated as full data width.
// ---------------------------------------------------------------------------

// One byte lane of the backing store. Combinational read so the top level
// can register the lane output straight into the R data register.
module axi_sram_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  // No reset: memory contents survive AXI_RST_i.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module axi_sram_slave #(
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                AXI_CLK_i,
  input  logic                AXI_RST_i,
  // write address
  input  logic [ID_W-1:0]     AWID_i,
  input  logic [ADDR_W-1:0]   AWADDR_i,
  input  logic [LEN_W-1:0]    AWLEN_i,
  input  logic [2:0]          AWSIZE_i,
  input  logic [1:0]          AWBURST_i,
  input  logic                AWVALID_i,
  output logic                AWREADY_o,
  // write data
  input  logic [DATA_W-1:0]   WDATA_i,
  input  logic [DATA_W/8-1:0] WSTRB_i,
  input  logic                WLAST_i,
  input  logic                WVALID_i,
  output logic                WREADY_o,
  // write response
  output logic [ID_W-1:0]     BID_o,
  output logic [1:0]          BRESP_o,
  output logic                BVALID_o,
  input  logic                BREADY_i,
  // read address
  input  logic [ID_W-1:0]     ARID_i,
  input  logic [ADDR_W-1:0]   ARADDR_i,
  input  logic [LEN_W-1:0]    ARLEN_i,
  input  logic [2:0]          ARSIZE_i,
  input  logic [1:0]          ARBURST_i,
  input  logic                ARVALID_i,
  output logic                ARREADY_o,
  // read data
  output logic [ID_W-1:0]     RID_o,
  output logic [DATA_W-1:0]   RDATA_o,
  output logic [1:0]          RRESP_o,
  output logic                RLAST_o,
  output logic                RVALID_o,
  input  logic                RREADY_i
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = LEN_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_BRESP = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  localparam logic PTR_READ  = 1'b0;
  localparam logic PTR_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Latched request of the transaction in flight.
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DEPTH_LOG2-1:0] addr;
    logic [LEN_W-1:0]      len;
    logic [1:0]            burst;
  } xact_t;

  logic [1:0]  state;
  logic        ptr;
  xact_t       xq;
  // Write side: beats received so far (saturating, one bit wider than LEN so
  // over-long bursts can never alias back onto len). Read side: index of the
  // beat currently presented on R.
  logic [CNT_W-1:0] beat;

  logic             bvalid_q;
  logic [ID_W-1:0]  bid_q;
  logic [1:0]       bresp_q;

  logic             rvalid_q;
  logic             rlast_q;
  logic [ID_W-1:0]  rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]       rresp_q;

  logic [DEPTH_LOG2-1:0] aw_word, ar_word, rd_addr;
  logic                  in_idle, ar_ready, aw_ready, w_ready, w_hs;
  logic                  beat_in_len, mem_we, r_hs;
  logic [STRB_W-1:0][7:0] rd_word;

  function automatic logic [DEPTH_LOG2-1:0] next_addr(
    input logic [DEPTH_LOG2-1:0] a,
    input logic [1:0]            burst
  );
    // Only INCR advances; the natural DEPTH_LOG2-bit overflow gives the
    // wrap-around at the top of memory.
    return (burst == BURST_INCR) ? a + DEPTH_LOG2'(1) : a;
  endfunction

  assign aw_word = AWADDR_i[DEPTH_LOG2+1:2];
  assign ar_word = ARADDR_i[DEPTH_LOG2+1:2];

  // Readies are held low while reset is asserted so nothing is accepted in
  // the reset cycle itself.
  assign in_idle  = (state == S_IDLE) && !AXI_RST_i;
  assign ar_ready = in_idle && ARVALID_i && (!AWVALID_i || ptr == PTR_READ);
  assign aw_ready = in_idle && AWVALID_i && (!ARVALID_i || ptr == PTR_WRITE);
  assign w_ready  = (state == S_WDATA) && !AXI_RST_i;
  assign w_hs     = w_ready && WVALID_i;
  assign r_hs     = (state == S_RDATA) && rvalid_q && RREADY_i;

  // Beats past len+1 and any WRAP/reserved burst are acknowledged but never
  // stored.
  assign beat_in_len = beat <= {1'b0, xq.len};
  assign mem_we      = w_hs && beat_in_len && !xq.burst[1];

  // In IDLE the banks look up the incoming AR address so the first beat is
  // captured on the AR handshake edge; afterwards they follow the latched
  // (already advanced) burst address.
  assign rd_addr = (state == S_IDLE) ? ar_word : xq.addr;

  for (genvar b = 0; b < STRB_W; b++) begin : g_lane
    axi_sram_bank #(.AW(DEPTH_LOG2)) u_bank (
      .clk   (AXI_CLK_i),
      .we    (mem_we && WSTRB_i[b]),
      .waddr (xq.addr),
      .wdata (WDATA_i[b*8 +: 8]),
      .raddr (rd_addr),
      .rdata (rd_word[b])
    );
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      state    <= S_IDLE;
      ptr      <= PTR_READ;
      xq       <= '0;
      beat     <= '0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          // ar_ready and aw_ready are mutually exclusive by construction.
          if (ar_ready) begin
            xq.id    <= ARID_i;
            xq.addr  <= next_addr(ar_word, ARBURST_i);
            xq.len   <= ARLEN_i;
            xq.burst <= ARBURST_i;
            beat     <= '0;
            ptr      <= PTR_WRITE;
            rvalid_q <= 1'b1;
            rlast_q  <= (ARLEN_i == '0);
            rid_q    <= ARID_i;
            rdata_q  <= ARBURST_i[1] ? '0 : rd_word;
            rresp_q  <= ARBURST_i[1] ? RESP_SLVERR : RESP_OKAY;
            state    <= S_RDATA;
          end else if (aw_ready) begin
            xq.id    <= AWID_i;
            xq.addr  <= aw_word;
            xq.len   <= AWLEN_i;
            xq.burst <= AWBURST_i;
            beat     <= '0;
            ptr      <= PTR_READ;
            state    <= S_WDATA;
          end
        end

        S_WDATA: begin
          if (w_hs) begin
            xq.addr <= next_addr(xq.addr, xq.burst);
            beat    <= (beat == '1) ? beat : beat + CNT_W'(1);
            if (WLAST_i) begin
              // beat still counts the beats before this one, so a correct
              // burst ends with beat == len.
              bvalid_q <= 1'b1;
              bid_q    <= xq.id;
              bresp_q  <= (beat != {1'b0, xq.len} || xq.burst[1])
                          ? RESP_SLVERR : RESP_OKAY;
              state    <= S_BRESP;
            end
          end
        end

        S_BRESP: begin
          if (BREADY_i) begin
            bvalid_q <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_RDATA: begin
          // R registers only move on a handshake, which keeps every R output
          // frozen across RREADY stalls.
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              rdata_q <= xq.burst[1] ? '0 : rd_word;
              rlast_q <= (beat + CNT_W'(1)) == {1'b0, xq.len};
              beat    <= beat + CNT_W'(1);
              xq.addr <= next_addr(xq.addr, xq.burst);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign AWREADY_o = aw_ready;
  assign ARREADY_o = ar_ready;
  assign WREADY_o  = w_ready;
  assign BVALID_o  = bvalid_q;
  assign BID_o     = bid_q;
  assign BRESP_o   = bresp_q;
  assign RVALID_o  = rvalid_q;
  assign RLAST_o   = rlast_q;
  assign RID_o     = rid_q;
  assign RDATA_o   = rdata_q;
  assign RRESP_o   = rresp_q;

  // Size fields and address bits outside the word index carry no meaning
  // for this memory.
  logic unused_bits;
  assign unused_bits = ^{AWSIZE_i, ARSIZE_i, AWADDR_i[1:0], ARADDR_i[1:0],
                         AWADDR_i[ADDR_W-1:DEPTH_LOG2+2],
                         ARADDR_i[ADDR_W-1:DEPTH_LOG2+2]};
endmodule
